// File: rtl/result_readout_seq.sv
// Result-dump sequencer: waits for the core to go idle, then streams a block of
// result RAM through NPORT read ports as lane-packed valid/ready beats.
module result_readout_seq #(
  parameter int WORD_W = 256,
  parameter int ADDR_W = 10,
  parameter int NPORT  = 2,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          word_cnt,
  input  logic                      abort,
  input  logic                      core_busy,
  output logic                      ref_sel,
  output logic [NPORT*ADDR_W-1:0]   raddr,
  input  logic [NPORT*WORD_W-1:0]   rdata,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [NPORT*WORD_W-1:0]   o_data,
  output logic [NPORT-1:0]          o_mask,
  output logic                      o_last,
  output logic                      busy,
  output logic                      done
);

  localparam int D     = RD_LAT + 2;
  localparam int PW    = 3;
  localparam int DEPTH = 2 ** PW;
  localparam int CW    = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic                       done_q, done_d;
  logic [NPORT*ADDR_W-1:0]    raddr_q;
  logic [ADDR_W-1:0]          next_q;
  logic [CNT_W-1:0]           rem_q;
  logic [RD_LAT:0]            vld_pipe_q;
  logic [RD_LAT:0]            last_pipe_q;
  logic [RD_LAT:0][NPORT-1:0] mask_pipe_q;
  logic [NPORT*WORD_W-1:0]    fdata_q [DEPTH];
  logic [NPORT-1:0]           fmask_q [DEPTH];
  logic                       flast_q [DEPTH];
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              cnt_q;

  logic                       issue, pop, cap, flush, beat_last, drain_done;
  logic [CW-1:0]              inflight;
  logic [NPORT-1:0]           beat_mask;
  logic [NPORT*ADDR_W-1:0]    beat_addr;
  logic [NPORT*WORD_W-1:0]    cap_data;

  assign flush     = abort && (state_q != S_IDLE);
  assign pop       = o_valid && o_ready;
  assign cap       = vld_pipe_q[RD_LAT];
  assign beat_last = (rem_q <= CNT_W'(NPORT));

  always_comb begin
    inflight = '0;
    for (int k = 0; k <= RD_LAT; k++) inflight = inflight + CW'(vld_pipe_q[k]);
  end

  // Credit counts the entry leaving this cycle as free, so a steady
  // one-beat-per-cycle stream never stalls while total storage stays <= D.
  assign issue = (state_q == S_READ) && !abort && ((cnt_q + inflight) < (CW'(D) + CW'(pop)));

  for (genvar i = 0; i < NPORT; i++) begin : g_lane
    assign beat_mask[i] = (rem_q > CNT_W'(i));
    assign beat_addr[i*ADDR_W +: ADDR_W] = beat_mask[i] ? next_q + ADDR_W'(i) : next_q;
    assign cap_data[i*WORD_W +: WORD_W]  = mask_pipe_q[RD_LAT][i] ? rdata[i*WORD_W +: WORD_W] : '0;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start && !abort) begin
                 if (word_cnt != '0) state_d = S_WAIT;
                 else                done_d  = 1'b1;
               end
      S_WAIT:  if (!core_busy) state_d = S_READ;
      S_READ:  if (issue && beat_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && o_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr_q <= '0;
      next_q  <= '0;
      rem_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        next_q <= base_addr;
        rem_q  <= word_cnt;
      end
    end else if (issue) begin
      raddr_q <= beat_addr;
      next_q  <= next_q + ADDR_W'(NPORT);
      rem_q   <= beat_last ? '0 : rem_q - CNT_W'(NPORT);
    end
  end

  // Read-latency tracker; clearing it on abort drops any late rdata.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      mask_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[RD_LAT-1:0], issue};
      last_pipe_q <= {last_pipe_q[RD_LAT-1:0], issue && beat_last};
      mask_pipe_q <= {mask_pipe_q[RD_LAT-1:0], beat_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (cap) wptr_q <= (wptr_q == PW'(D-1)) ? '0 : wptr_q + 1'b1;
      if (pop) rptr_q <= (rptr_q == PW'(D-1)) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(cap) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      fdata_q[wptr_q] <= cap_data;
      fmask_q[wptr_q] <= mask_pipe_q[RD_LAT];
      flast_q[wptr_q] <= last_pipe_q[RD_LAT];
    end
  end

  assign drain_done = (state_q == S_DRAIN) && pop && o_last && !abort;

  assign raddr   = raddr_q;
  assign o_valid = (cnt_q != '0);
  assign o_data  = o_valid ? fdata_q[rptr_q] : '0;
  assign o_mask  = o_valid ? fmask_q[rptr_q] : '0;
  assign o_last  = o_valid && flast_q[rptr_q];
  assign busy    = (state_q != S_IDLE);
  assign ref_sel = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done    = done_q || drain_done;

endmodule

// File: tb/tb_result_readout_seq.sv
// Bench for result_readout_seq: RAM model with read latency, table + random
// dumps checked against a beat-level reference model, plus corner sequences.
module tb_result_readout_seq;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;
  localparam int NPORT  = 2;
  localparam int CNT_W  = 8;
  localparam int RD_LAT = 3;
  localparam int D      = RD_LAT + 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, core_busy = 1'b1, o_ready = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [CNT_W-1:0]        word_cnt  = '0;
  logic                    ref_sel, o_valid, o_last, busy, done;
  logic [NPORT*ADDR_W-1:0] raddr;
  logic [NPORT*WORD_W-1:0] rdata, o_data;
  logic [NPORT-1:0]        o_mask;

  int n_chk = 0, n_fail = 0, cyc = 0;

  result_readout_seq #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .NPORT(NPORT), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .abort(abort), .core_busy(core_busy), .ref_sel(ref_sel), .raddr(raddr), .rdata(rdata),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_mask(o_mask), .o_last(o_last),
    .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'(a) * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  logic [NPORT*ADDR_W-1:0] rp [RD_LAT];
  always @(posedge clk) begin
    rp[0] <= raddr;
    for (int k = 1; k < RD_LAT; k++) rp[k] <= rp[k-1];
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NPORT; i++) rdata[i*WORD_W +: WORD_W] = mem_word(rp[RD_LAT-1][i*ADDR_W +: ADDR_W]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [NPORT*WORD_W-1:0] data; logic [NPORT-1:0] mask; logic last; } beat_t;
  typedef struct { logic [ADDR_W-1:0] base; int cnt; int pct; int exp_beats; logic [NPORT-1:0] exp_lmask; bit poke; } vec_t;

  beat_t                   got_q[$], exp_q[$];
  logic [NPORT*ADDR_W-1:0] exp_raddr[$];
  int                      done_q[$];
  int                      issued = 0, max_out = 0;
  logic                    pv = 1'b0, pr = 1'b0;
  beat_t                   pb;

  // Reference: beat k lane i carries word base+k*NPORT+i (mod 2^ADDR_W); padding lanes are zero/unmasked
  function automatic void build_model(input logic [ADDR_W-1:0] b, input int cnt);
    int nb, idx;
    beat_t e;
    logic [NPORT*ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] a, a0;
    nb = (cnt + NPORT - 1) / NPORT;
    exp_q.delete();
    exp_raddr.delete();
    for (int k = 0; k < nb; k++) begin
      e.data = '0; e.mask = '0; e.last = (k == nb - 1); ra = '0;
      a0 = ADDR_W'(int'(b) + k * NPORT);
      for (int i = 0; i < NPORT; i++) begin
        idx = k * NPORT + i;
        a = ADDR_W'(int'(b) + idx);
        if (idx < cnt) begin
          e.data[i*WORD_W +: WORD_W] = mem_word(a);
          e.mask[i] = 1'b1;
          ra[i*ADDR_W +: ADDR_W] = a;
        end else ra[i*ADDR_W +: ADDR_W] = a0;
      end
      exp_q.push_back(e);
      exp_raddr.push_back(ra);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (issued < exp_raddr.size() && raddr[ADDR_W-1:0] == exp_raddr[issued][ADDR_W-1:0]) begin
        chk("raddr", 64'(raddr), 64'(exp_raddr[issued]));
        issued++;
      end
      if (issued - got_q.size() > max_out) max_out = issued - got_q.size();
      if (pv && !pr) begin
        chk("hold_data", 64'(o_data), 64'(pb.data));
        chk("hold_ctl", {o_valid, o_last, o_mask}, {1'b1, pb.last, pb.mask});
      end
      if (o_valid && o_ready) got_q.push_back('{o_data, o_mask, o_last});
      if (done) done_q.push_back(cyc);
      pv = o_valid; pr = o_ready;
      pb.data = o_data; pb.mask = o_mask; pb.last = o_last;
    end
  end

  task automatic clear_mon();
    got_q.delete(); done_q.delete(); issued = 0; max_out = 0;
  endtask

  task automatic compare_beats(input int n);
    for (int k = 0; k < n; k++) begin
      chk("beat_data", 64'(got_q[k].data), 64'(exp_q[k].data));
      chk("beat_ctl", {got_q[k].last, got_q[k].mask}, {exp_q[k].last, exp_q[k].mask});
    end
  endtask

  task automatic run_dump(input vec_t v);
    int t, guard, n;
    build_model(v.base, v.cnt);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; word_cnt = CNT_W'(v.cnt); core_busy = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("busy_after_start", busy, 1);
    repeat (5) @(posedge clk);
    #1 core_busy = 1'b0;
    t = cyc + 1;
    guard = 0;
    while (done_q.size() == 0 && guard < 600) begin
      @(posedge clk); #1;
      guard++;
      o_ready = ($urandom_range(99) < v.pct);
      if (guard == 2) core_busy = 1'b1;
      if (v.poke) begin
        if (guard == 3) begin start = 1'b1; base_addr = 10'h200; word_cnt = 3; end
        else start = 1'b0;
      end
    end
    chk("done_seen", done_q.size() != 0, 1);
    o_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_once", done_q.size(), 1);
    chk("idle_busy", busy, 0);
    chk("idle_ref_sel", ref_sel, 0);
    chk("n_beats", got_q.size(), v.exp_beats);
    if (got_q.size() > 0) chk("last_mask", got_q[got_q.size()-1].mask, v.exp_lmask);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    compare_beats(n);
    chk("all_issued", issued, exp_q.size());
    chk("outstanding_le_D", max_out <= D, 1);
    if (v.pct == 100 && done_q.size() > 0) chk("done_cycle", done_q[0], t + v.exp_beats + RD_LAT + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int n;
    vecs[0] = '{10'h040, 24, 100, 12, 2'b11, 1'b0};
    vecs[1] = '{10'h010,  5, 100,  3, 2'b01, 1'b0};
    vecs[2] = '{10'h3FE,  4, 100,  2, 2'b11, 1'b0};
    vecs[3] = '{10'h040, 24,  30, 12, 2'b11, 1'b0};
    vecs[4] = '{10'h3FF,  7,  60,  4, 2'b01, 1'b0};
    vecs[5] = '{10'h123,  1, 100,  1, 2'b01, 1'b0};
    vecs[6] = '{10'h080,  8, 100,  4, 2'b11, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_raddr", 64'(raddr), 0);
    chk("rst_data", 64'(o_data), 0);
    chk("rst_ctl", {o_valid, o_mask, o_last, ref_sel, busy, done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_dump(vecs[i]);

    for (int r = 0; r < 4; r++) begin
      rv.base = ADDR_W'($urandom);
      while (rv.base == raddr[ADDR_W-1:0]) rv.base = rv.base + 10'd4;
      rv.cnt = $urandom_range(30, 1);
      rv.pct = $urandom_range(100, 20);
      rv.exp_beats = (rv.cnt + 1) / 2;
      rv.exp_lmask = (rv.cnt % 2) ? 2'b01 : 2'b11;
      rv.poke = 1'b0;
      run_dump(rv);
    end

    // zero-length request
    exp_raddr.delete(); clear_mon();
    @(posedge clk); #1 start = 1'b1; word_cnt = 0; base_addr = 10'h005;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("zero_done", done, 1); chk("zero_busy", busy, 0);
    @(negedge clk); chk("zero_done_pulse", done, 0);
    repeat (4) @(negedge clk);
    chk("zero_beats", got_q.size(), 0);

    // start and abort together from IDLE
    clear_mon();
    @(posedge clk); #1 start = 1'b1; abort = 1'b1; word_cnt = 6;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk); chk("sa_busy", busy, 0); chk("sa_done", done, 0);
    repeat (10) @(negedge clk);
    chk("sa_ref_sel", ref_sel, 0);
    chk("sa_no_beats", got_q.size(), 0);
    chk("sa_no_done", done_q.size(), 0);

    // abort around beat 4 of 12
    build_model(10'h040, 24); clear_mon();
    @(posedge clk); #1 start = 1'b1; base_addr = 10'h040; word_cnt = 24; core_busy = 1'b1; o_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 core_busy = 1'b0;
    for (int g = 0; g < 100 && got_q.size() < 3; g++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_done", done, 1); chk("abort_valid", o_valid, 0);
    n = got_q.size();
    repeat (RD_LAT + 6) @(negedge clk);
    chk("abort_no_more_beats", got_q.size(), n);
    chk("abort_done_once", done_q.size(), 1);
    chk("abort_ref_sel", ref_sel, 0);
    chk("abort_beats_le4", n <= 4 && n >= 3, 1);
    compare_beats((n < exp_q.size()) ? n : exp_q.size());

    // reset while in DRAIN with beats held by backpressure
    build_model(10'h100, 4); clear_mon();
    @(posedge clk); #1 start = 1'b1; base_addr = 10'h100; word_cnt = 4; core_busy = 1'b1; o_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0; core_busy = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); chk("pre_rst_valid", o_valid, 1); chk("pre_rst_busy", busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_raddr", 64'(raddr), 0);
    chk("rst_mid_data", 64'(o_data), 0);
    chk("rst_mid_ctl", {o_valid, o_mask, o_last, ref_sel, busy, done}, 0);
    @(posedge clk); #1 rst_n = 1'b1; o_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_done", done_q.size(), 0);
    chk("rst_mid_no_beats", got_q.size(), 0);
    chk("rst_mid_idle_valid", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
